chunked_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder built from one CHUNK-bit full-adder slice.

---
 rtl/chunked_serial_adder.sv | 123 ++++++++++++
 tb/tb_chunked_serial_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chunked_serial_adder: WIDTH-bit add done CHUNK bits per cycle, carry     |
// | registered between chunks, result returned over valid/ready. Rev 1.0     |
// +--------------------------------------------------------------------------+
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int            c_NCH  = WIDTH / CHUNK;
  localparam int            c_CW   = (c_NCH > 1) ? $clog2(c_NCH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_out_sum;
  logic              r_out_cout;

  logic [CHUNK:0]    w_slice;
  logic [WIDTH-1:0]  w_s_ext;
  logic [WIDTH-1:0]  w_sum_nxt;
  logic              w_last;

  assign w_slice   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};
  assign w_s_ext   = WIDTH'(w_slice[CHUNK-1:0]);
  // Each new chunk enters at the top so the low chunk lands at bit 0 after NCH steps.
  assign w_sum_nxt = (r_sum >> CHUNK) | (w_s_ext << (WIDTH - CHUNK));
  assign w_last    = (r_cnt == c_LAST);

  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_slice[CHUNK];
          r_sum   <= w_sum_nxt;
          if (w_last) begin
            r_out_sum  <= w_sum_nxt;
            r_out_cout <= w_slice[CHUNK];
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunked_serial_adder.sv
`default_nettype none
// Bench for chunked_serial_adder: directed vectors on the default build plus
// 6/2 and 8/1 configurations, with random operands checked against a+b+cin.
module tb_chunked_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [7:0] in_a, in_b, out_sum;

  logic       v6, ir6, c6, ov6, or6, co6;
  logic [5:0] a6, b6, s6;

  logic       v1, ir1, c1, ov1, or1, co1;
  logic [7:0] a1, b1, s1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  chunked_serial_adder #(.WIDTH(6), .CHUNK(2)) dut_w6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v6), .in_ready(ir6),
    .in_a(a6), .in_b(b6), .in_cin(c6),
    .out_valid(ov6), .out_ready(or6),
    .out_sum(s6), .out_cout(co6)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .in_cin(c1),
    .out_valid(ov1), .out_ready(or1),
    .out_sum(s1), .out_cout(co1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the default DUT idle; returns at a negedge after the result is consumed.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] exp_sum, input logic exp_cout, input int stall);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_op", in_ready, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = ci;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
    in_cin   = 1'($urandom);
    check("in_ready_in_add", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("sum", out_sum, exp_sum);
    check("cout", out_cout, exp_cout);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum", out_sum, exp_sum);
      check("stall_cout", out_cout, exp_cout);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("valid_after_consume", out_valid, 0);
    check("in_ready_after_consume", in_ready, 1);
    check("sum_held", out_sum, exp_sum);
  endtask

  task automatic run6(input logic [5:0] a, input logic [5:0] b, input logic ci);
    logic [6:0] e;
    int lat;
    e   = {1'b0, a} + {1'b0, b} + {6'd0, ci};
    check("w6_ready", ir6, 1);
    v6 = 1'b1; a6 = a; b6 = b; c6 = ci; or6 = 1'b0;
    @(negedge clk);
    v6  = 1'b0;
    lat = 0;
    while (!ov6 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("w6_latency", lat, 3);
    check("w6_sum", s6, e[5:0]);
    check("w6_cout", co6, e[6]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    or6 = 1'b1;
    @(negedge clk);
    or6 = 1'b0;
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [8:0] e;
    int lat;
    e   = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    check("c1_ready", ir1, 1);
    v1 = 1'b1; a1 = a; b1 = b; c1 = ci; or1 = 1'b0;
    @(negedge clk);
    v1  = 1'b0;
    lat = 0;
    while (!ov1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("c1_latency", lat, 8);
    check("c1_sum", s1, e[7:0]);
    check("c1_cout", co1, e[8]);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] e;
    logic       seen;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    v6 = 1'b0; a6 = '0; b6 = '0; c6 = 1'b0; or6 = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
    run_op(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1);
    run_op(8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 0);
    run_op(8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 5);

    // Abort an add with the counter at 2; reset lands between clock edges.
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", out_sum, 0);
    check("abort_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check("abort_ready_after", in_ready, 1);
    run_op(8'hC3, 8'h3D, 1'b1, 8'h01, 1'b1, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, e[7:0], e[8], int'($urandom_range(0, 3)));
    end

    run6(6'h3F, 6'h01, 1'b0);
    run6(6'h15, 6'h2A, 1'b1);
    for (int i = 0; i < 300; i++) run6(6'($urandom), 6'($urandom), 1'($urandom));

    run1(8'hFF, 8'hFF, 1'b1);
    run1(8'h01, 8'h7F, 1'b0);
    for (int i = 0; i < 300; i++) run1(8'($urandom), 8'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
